// File: rtl/requant_32to8.sv
`default_nettype none
// ============================================================================
// Module   : requant_32to8
// Purpose  : Requantizes signed 32-bit accumulator words to signed int8:
//            d_out = sat8(round((acc * M) >>> S) + ZP), 3-stage pipeline with
//            valid/ready flow control and a clipped-beat event counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-low reset
//   in_valid     in   1      input beat valid
//   in_ready     out  1      beat accepted this cycle when in_valid is high
//   acc_in       in   32     signed accumulator value
//   scale_m      in   16     unsigned multiplier M (sampled per beat)
//   scale_shift  in   5      right shift S, 0..31 (sampled per beat)
//   zero_point   in   8      signed output zero point ZP (sampled per beat)
//   out_valid    out  1      output beat valid
//   out_ready    in   1      downstream accepts beat
//   d_out        out  8      signed int8 result
//   sat_flag     out  1      beat was clipped to the int8 range
//   sat_clr      in   1      synchronous clear of sat_cnt (wins over increment)
//   sat_cnt      out  CNT_W  clipped beats delivered, sticks at all-ones
// Configuration macro:
//   REQUANT_RELU_EN - lower clip bound becomes max(-128, ZP); the ReLU floor
//                     by itself does not raise sat_flag.
// ============================================================================
module requant_32to8 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      acc_in,
  input  logic [15:0]      scale_m,
  input  logic [4:0]       scale_shift,
  input  logic [7:0]       zero_point,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       d_out,
  output logic             sat_flag,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic signed [49:0] c_MAX = 50'sd127;
  localparam logic signed [49:0] c_MIN = -50'sd128;

  // Single global advance: the whole pipe moves or freezes together, so
  // bubbles are kept and ordering is trivially preserved.
  logic w_en;
  assign w_en     = ~out_valid | out_ready;
  assign in_ready = w_en;

  // ---------------- Stage 1: product ----------------
  logic signed [48:0] w_acc_ext;
  logic signed [48:0] w_m_ext;
  logic signed [48:0] w_prod;
  logic               r_v1;
  logic signed [48:0] r_p1;
  logic [4:0]         r_s1;
  logic [7:0]         r_zp1;

  // |acc*M| < 2^47, so a 49-bit signed product cannot overflow.
  assign w_acc_ext = $signed({{17{acc_in[31]}}, acc_in});
  assign w_m_ext   = $signed({33'd0, scale_m});
  assign w_prod    = w_acc_ext * w_m_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1  <= 1'b0;
      r_p1  <= '0;
      r_s1  <= '0;
      r_zp1 <= '0;
    end else if (w_en) begin
      r_v1  <= in_valid;
      r_p1  <= w_prod;
      r_s1  <= scale_shift;
      r_zp1 <= zero_point;
    end
  end

  // ---------------- Stage 2: rounding shift ----------------
  logic signed [48:0] w_half;
  logic signed [48:0] w_sum;
  logic signed [48:0] w_round;
  logic               r_v2;
  logic signed [48:0] r_r2;
  logic [7:0]         r_zp2;

  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  always_comb begin
    w_half  = '0;
    w_sum   = r_p1;
    w_round = r_p1;
    if (r_s1 != 5'd0) begin
      w_half  = 49'sd1 <<< (r_s1 - 5'd1);
      w_sum   = r_p1 + w_half;
      w_round = w_sum >>> r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v2  <= 1'b0;
      r_r2  <= '0;
      r_zp2 <= '0;
    end else if (w_en) begin
      r_v2  <= r_v1;
      r_r2  <= w_round;
      r_zp2 <= r_zp1;
    end
  end

  // ---------------- Stage 3: zero point + clip ----------------
  logic signed [49:0] w_zp_ext;
  logic signed [49:0] w_v;
  logic               w_hi;
  logic               w_lo;
  logic [7:0]         w_d;
  logic               w_sat;

  assign w_zp_ext = $signed({{42{r_zp2[7]}}, r_zp2});
  assign w_v      = $signed({r_r2[48], r_r2}) + w_zp_ext;
  assign w_hi     = (w_v > c_MAX);
  assign w_lo     = (w_v < c_MIN);
  // sat_flag reports leaving the int8 range, independent of any ReLU floor.
  assign w_sat    = w_hi | w_lo;

`ifdef REQUANT_RELU_EN
  // ZP is itself int8, so max(-128, ZP) == ZP and the floor covers w_lo.
  logic w_floor;
  assign w_floor = (w_v < w_zp_ext);
  always_comb begin
    w_d = w_v[7:0];
    if (w_hi) begin
      w_d = 8'h7F;
    end else if (w_floor) begin
      w_d = r_zp2;
    end
  end
`else
  always_comb begin
    w_d = w_v[7:0];
    if (w_hi) begin
      w_d = 8'h7F;
    end else if (w_lo) begin
      w_d = 8'h80;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      d_out     <= '0;
      sat_flag  <= 1'b0;
    end else if (w_en) begin
      out_valid <= r_v2;
      d_out     <= w_d;
      sat_flag  <= w_sat;
    end
  end

  // ---------------- Saturation event counter ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_valid && out_ready && sat_flag && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire
